// File: rtl/baopoco_ctrl_decode.sv
// rtl/baopoco_ctrl_decode.sv - qualifies the baopoco_ctrl word and turns it into sync/arm/reset events
// Glitch-qualified control levels, arm/sync FSM, wrapping sync counter and stretched counter reset.
module baopoco_ctrl_decode #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned RST_LEN       = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic [31:0]      ctrl_word,
  input  logic             sync_in,
  output logic             sync_out,
  output logic             armed,
  output logic             rst_out,
  output logic             sync_sel,
  output logic [15:0]      ctrl_field,
  output logic [CNT_W-1:0] sync_count
);

  localparam logic [7:0]  SCNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] RST_LOAD = 16'(RST_LEN);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  logic [31:0]      cand_q, cand_d;
  logic [7:0]       scnt_q, scnt_d;
  // Only the meaningful bits of the accepted word are kept: {[31:16], [3:0]}.
  logic [19:0]      qual_q, qual_d;
  logic [2:0]       qual_prev_q, qual_prev_d;
  state_t           state_q, state_d;
  logic             sync_out_q, sync_out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      stretch_q, stretch_d;
  logic [2:0]       rise;
  logic             trig;

  always_comb begin
    cand_d      = ctrl_word;
    scnt_d      = scnt_q;
    qual_d      = qual_q;
    qual_prev_d = qual_q[2:0];
    if (ctrl_word != cand_q) begin
      scnt_d = '0;
    end else if (scnt_q != SCNT_MAX) begin
      scnt_d = scnt_q + 8'd1;
    end
    if (scnt_q == SCNT_MAX) begin
      qual_d = {cand_q[31:16], cand_q[3:0]};
    end
  end

  always_comb begin
    rise = qual_q[2:0] & ~qual_prev_q;
    trig = qual_q[3] ? rise[1] : sync_in;
  end

  always_comb begin
    state_d    = state_q;
    sync_out_d = 1'b0;
    count_d    = count_q;
    stretch_d  = stretch_q;
    case (state_q)
      S_IDLE: begin
        if (rise[0]) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (trig) begin
          sync_out_d = 1'b1;
          count_d    = count_q + CNT_W'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A counter reset overrides a same-edge increment.
    if (rise[2]) begin
      count_d   = '0;
      stretch_d = RST_LOAD;
    end else if (stretch_q != 16'd0) begin
      stretch_d = stretch_q - 16'd1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cand_q      <= '0;
      scnt_q      <= '0;
      qual_q      <= '0;
      qual_prev_q <= '0;
      state_q     <= S_IDLE;
      sync_out_q  <= 1'b0;
      count_q     <= '0;
      stretch_q   <= '0;
    end else begin
      cand_q      <= cand_d;
      scnt_q      <= scnt_d;
      qual_q      <= qual_d;
      qual_prev_q <= qual_prev_d;
      state_q     <= state_d;
      sync_out_q  <= sync_out_d;
      count_q     <= count_d;
      stretch_q   <= stretch_d;
    end
  end

  assign sync_out   = sync_out_q;
  assign armed      = (state_q == S_ARMED);
  assign rst_out    = (stretch_q != 16'd0);
  assign sync_sel   = qual_q[3];
  assign ctrl_field = qual_q[19:4];
  assign sync_count = count_q;

endmodule

// File: tb/tb_baopoco_ctrl_decode.sv
// tb/tb_baopoco_ctrl_decode.sv - self-checking bench for baopoco_ctrl_decode
// Sliding-window behavioural model checked every cycle, plus directed literal expectations.
module tb_baopoco_ctrl_decode;

  localparam int S  = 4;
  localparam int RL = 16;
  localparam int CW = 4;

  logic          user_clk  = 1'b0;
  logic          user_rst  = 1'b1;
  logic [31:0]   ctrl_word = 32'h0;
  logic          sync_in   = 1'b0;
  logic          sync_out;
  logic          armed;
  logic          rst_out;
  logic          sync_sel;
  logic [15:0]   ctrl_field;
  logic [CW-1:0] sync_count;

  always #5 user_clk = ~user_clk;

  baopoco_ctrl_decode #(
    .STABLE_CYCLES(S),
    .RST_LEN(RL),
    .CNT_W(CW)
  ) dut (
    .user_clk(user_clk),
    .user_rst(user_rst),
    .ctrl_word(ctrl_word),
    .sync_in(sync_in),
    .sync_out(sync_out),
    .armed(armed),
    .rst_out(rst_out),
    .sync_sel(sync_sel),
    .ctrl_field(ctrl_field),
    .sync_count(sync_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is accepted once the last S samples (reset counts as a 0 sample) agree.
  logic [31:0] hist[$];
  logic [31:0] m_qual      = 32'h0;
  logic [31:0] m_qual_prev = 32'h0;
  logic [2:0]  m_rise;
  logic        m_trig;
  bit          m_stable;
  bit          m_armed     = 1'b0;
  bit          m_sync_out  = 1'b0;
  int          m_count     = 0;
  int          m_edge      = 0;
  int          m_rst_edge  = -1000000;
  bit          chk_en      = 1'b0;
  int          sync_pulses = 0;
  int          rst_hi      = 0;

  always @(posedge user_clk) begin
    m_edge++;
    if (user_rst) begin
      hist        = {32'h0};
      m_qual      = 32'h0;
      m_qual_prev = 32'h0;
      m_armed     = 1'b0;
      m_sync_out  = 1'b0;
      m_count     = 0;
      m_rst_edge  = -1000000;
    end else begin
      m_rise     = m_qual[2:0] & ~m_qual_prev[2:0];
      m_trig     = m_qual[3] ? m_rise[1] : sync_in;
      m_sync_out = 1'b0;
      if (!m_armed) begin
        if (m_rise[0]) m_armed = 1'b1;
      end else if (m_trig) begin
        m_sync_out = 1'b1;
        m_count    = (m_count + 1) % (1 << CW);
        m_armed    = 1'b0;
      end
      if (m_rise[2]) begin
        m_count    = 0;
        m_rst_edge = m_edge;
      end
      m_stable = (hist.size() == S);
      for (int i = 0; i < hist.size(); i++) begin
        if (hist[i] != hist[hist.size()-1]) m_stable = 1'b0;
      end
      m_qual_prev = m_qual;
      if (m_stable) m_qual = hist[hist.size()-1];
      hist.push_back(ctrl_word);
      if (hist.size() > S) void'(hist.pop_front());
    end
  end

  always @(negedge user_clk) begin
    if (chk_en) begin
      chk("sync_out", {31'b0, sync_out}, {31'b0, m_sync_out});
      chk("armed", {31'b0, armed}, {31'b0, m_armed});
      chk("rst_out", {31'b0, rst_out}, {31'b0, ((m_edge - m_rst_edge) < RL)});
      chk("sync_sel", {31'b0, sync_sel}, {31'b0, m_qual[3]});
      chk("ctrl_field", {16'b0, ctrl_field}, {16'b0, m_qual[31:16]});
      chk("sync_count", {28'b0, sync_count}, 32'(m_count));
      if (sync_out === 1'b1) sync_pulses++;
      if (rst_out === 1'b1) rst_hi++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge user_clk);
      #1;
    end
  endtask

  task automatic arm_sync();
    ctrl_word = 32'h0;
    tick(6);
    ctrl_word = 32'h1;
    tick(6);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sync_out"}, {31'b0, sync_out}, 32'h0);
    chk({tag, "_armed"}, {31'b0, armed}, 32'h0);
    chk({tag, "_rst_out"}, {31'b0, rst_out}, 32'h0);
    chk({tag, "_sync_sel"}, {31'b0, sync_sel}, 32'h0);
    chk({tag, "_ctrl_field"}, {16'b0, ctrl_field}, 32'h0);
    chk({tag, "_sync_count"}, {28'b0, sync_count}, 32'h0);
  endtask

  bit armed_seen = 1'b0;

  initial begin
    user_rst  = 1'b1;
    ctrl_word = 32'h0;
    tick(2);
    user_rst = 1'b0;
    chk_en   = 1'b1;
    chk_all_zero("reset");
    tick(2);

    // Reset then arm via sync_in.
    ctrl_word = 32'h1;
    tick(5);
    chk("arm_before_latency", {31'b0, armed}, 32'h0);
    tick(1);
    chk("arm_at_latency", {31'b0, armed}, 32'h1);
    tick(14);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    chk("first_sync_out", {31'b0, sync_out}, 32'h1);
    chk("first_count", {28'b0, sync_count}, 32'h1);
    chk("first_disarm", {31'b0, armed}, 32'h0);
    tick(1);
    chk("first_sync_one_cycle", {31'b0, sync_out}, 32'h0);

    // Glitch rejection.
    for (int i = 0; i < 17; i++) begin
      ctrl_word = (i % 2) ? 32'h1 : 32'h0;
      repeat (3) begin
        tick(1);
        if (armed) armed_seen = 1'b1;
      end
    end
    chk("glitch_armed", {31'b0, armed_seen}, 32'h0);
    chk("glitch_model_qual", m_qual, 32'h1);
    ctrl_word = 32'h0;
    tick(6);

    // Soft sync with sync_in ignored.
    sync_pulses = 0;
    ctrl_word   = 32'h8;
    tick(10);
    ctrl_word = 32'h9;
    tick(7);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    tick(2);
    ctrl_word = 32'hB;
    tick(10);
    chk("soft_pulses", 32'(sync_pulses), 32'h1);
    chk("soft_count", {28'b0, sync_count}, 32'h2);
    chk("soft_sync_sel", {31'b0, sync_sel}, 32'h1);

    // Counter reset and reload during stretch.
    repeat (3) arm_sync();
    tick(1);
    chk("pre_clear_count", {28'b0, sync_count}, 32'h5);
    rst_hi    = 0;
    ctrl_word = 32'h4;
    tick(6);
    chk("clr_rst_out", {31'b0, rst_out}, 32'h1);
    chk("clr_count", {28'b0, sync_count}, 32'h0);
    ctrl_word = 32'h0;
    tick(4);
    ctrl_word = 32'h4;
    tick(40);
    chk("stretch_reload_len", 32'(rst_hi), 32'd26);

    // Wrap with 4-bit counter.
    repeat (17) arm_sync();
    tick(1);
    chk("wrap_count", {28'b0, sync_count}, 32'h1);

    // Arm rise coinciding with sync_in while idle.
    ctrl_word = 32'h0;
    tick(6);
    ctrl_word = 32'h1;
    tick(5);
    sync_in = 1'b1;
    tick(1);
    sync_in = 1'b0;
    chk("simul_no_sync", {31'b0, sync_out}, 32'h0);
    chk("simul_armed", {31'b0, armed}, 32'h1);
    tick(1);
    chk("simul_still_no_sync", {31'b0, sync_out}, 32'h0);

    // Reset mid-stretch and mid-arm.
    ctrl_word = 32'h5;
    tick(6);
    chk("pre_rst_stretch", {31'b0, rst_out}, 32'h1);
    chk("pre_rst_armed", {31'b0, armed}, 32'h1);
    user_rst = 1'b1;
    tick(1);
    user_rst = 1'b0;
    chk_all_zero("midrst");
    tick(25);

    // Static field pass-through.
    ctrl_word = 32'hABCD_0008;
    tick(6);
    chk("field_value", {16'b0, ctrl_field}, 32'h0000_ABCD);
    chk("field_sync_sel", {31'b0, sync_sel}, 32'h1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
